// File: rtl/uart_tx_arb.sv
// uart_tx_arb: four-requester arbiter sharing one UART byte serializer
//   clk, rst       : system clock, synchronous active-high reset
//   txck           : bit-rate strobe, one clk wide
//   req, pd0..pd3  : per-requester level request and byte
//   ack            : one-hot pulse, byte of that requester taken
//   gnt            : one-hot frame owner, held for the whole frame
//   busy, tstart   : frame in progress, one-cycle start strobe
//   txpd           : byte to the serializer, held until the next grant
//   UART_ARB_FIXPRI_EN: fixed priority (requester 0 highest) instead of round-robin
module uart_tx_arb #(
  parameter int FRAME_TICKS = 11
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       txck,
  input  logic [3:0] req,
  input  logic [7:0] pd0,
  input  logic [7:0] pd1,
  input  logic [7:0] pd2,
  input  logic [7:0] pd3,
  output logic [3:0] ack,
  output logic [3:0] gnt,
  output logic       busy,
  output logic       tstart,
  output logic [7:0] txpd
);
  typedef enum logic {IDLE, BUSY} state_t;
  state_t state, nxt;
  logic [3:0] cnt, cnt_d, ack_d, gnt_d;
  logic [7:0] txpd_d, pd_w;
  logic [1:0] w;
  logic grab, fin, busy_d;
  assign grab = state == IDLE && |req;
  assign fin = state == BUSY && txck && cnt == 4'(FRAME_TICKS - 1);
  assign pd_w = w == 2'd0 ? pd0 : w == 2'd1 ? pd1 : w == 2'd2 ? pd2 : pd3;
`ifdef UART_ARB_FIXPRI_EN
  assign w = req[0] ? 2'd0 : req[1] ? 2'd1 : req[2] ? 2'd2 : 2'd3;
`else
  logic [1:0] ptr, own;
  logic [3:0] rot;
  // rot[i] is req[ptr+i], so the first set bit of rot is the search offset from ptr
  assign rot = 4'({req, req} >> ptr);
  assign w = ptr + (rot[0] ? 2'd0 : rot[1] ? 2'd1 : rot[2] ? 2'd2 : 2'd3);
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= 2'd0;
      own <= 2'd0;
    end else if (grab) own <= w;
    else if (fin) ptr <= own + 2'd1;
  end
`endif
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt <= 4'd0;
      ack <= 4'd0;
      gnt <= 4'd0;
      busy <= 1'b0;
      tstart <= 1'b0;
      txpd <= 8'h00;
    end else begin
      state <= nxt;
      cnt <= cnt_d;
      ack <= ack_d;
      gnt <= gnt_d;
      busy <= busy_d;
      tstart <= grab;
      txpd <= txpd_d;
    end
  end
  always_comb nxt = state == IDLE ? (|req ? BUSY : IDLE) : (fin ? IDLE : BUSY);
  always_comb begin
    ack_d = grab ? 4'b1 << w : 4'b0;
    gnt_d = grab ? 4'b1 << w : fin ? 4'b0 : gnt;
    busy_d = grab | (busy & ~fin);
    txpd_d = grab ? pd_w : txpd;
    cnt_d = grab ? 4'd0 : (state == BUSY && txck) ? cnt + 4'd1 : cnt;
  end
endmodule

// File: tb/tb_uart_tx_arb.sv
// tb_uart_tx_arb: randomized scoreboard bench for uart_tx_arb
module tb_uart_tx_arb;
  localparam int FT = 11;
  logic clk = 1'b0, rst = 1'b1, txck = 1'b0;
  logic [3:0] req = 4'b0, ack, gnt;
  logic [7:0] pdv [4];
  logic busy, tstart;
  logic [7:0] txpd;
  int total = 0, bad = 0, cyc = 0;
  typedef struct {int w; logic [7:0] b; int c;} exp_t;
  exp_t q[$];
  int eq[$];
  bit m_busy = 0, new_grant = 0;
  int m_ticks = 0, m_ptr = 0, m_own = 0, last_w = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  uart_tx_arb #(.FRAME_TICKS(FT)) dut (
    .clk(clk), .rst(rst), .txck(txck), .req(req),
    .pd0(pdv[0]), .pd1(pdv[1]), .pd2(pdv[2]), .pd3(pdv[3]),
    .ack(ack), .gnt(gnt), .busy(busy), .tstart(tstart), .txpd(txpd)
  );
  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
    end
  endtask
  function automatic int pick(input logic [3:0] r, input int p);
    for (int i = 0; i < 4; i++) if (r[(p + i) % 4]) return (p + i) % 4;
    return 0;
  endfunction
  // drive inputs for the coming edge and advance the reference model over that edge
  task automatic step(input logic r_rst, input logic [3:0] r_req, input logic r_txck);
    @(negedge clk);
    rst = r_rst;
    req = r_req;
    txck = r_txck;
    new_grant = 0;
    if (r_rst) begin
      m_busy = 0;
      m_ticks = 0;
      m_ptr = 0;
    end else if (!m_busy) begin
      if (r_req != 4'b0) begin
        last_w = pick(r_req, m_ptr);
        q.push_back('{w: last_w, b: pdv[last_w], c: cyc + 1});
        m_busy = 1;
        m_ticks = 0;
        m_own = last_w;
        new_grant = 1;
      end
    end else begin
      m_ticks += int'(r_txck);
      if (m_ticks == FT) begin
        m_busy = 0;
        eq.push_back(cyc + 1);
`ifndef UART_ARB_FIXPRI_EN
        m_ptr = (m_own + 1) % 4;
`endif
      end
    end
  endtask
  initial begin
    bit pbusy;
    int ticks, ec;
    logic [7:0] ptx;
    exp_t e;
    pbusy = 0;
    ticks = 0;
    ptx = 8'h00;
    forever begin
      @(posedge clk);
      #1;
      if (rst) begin
        check("rst_out", 32'({ack, gnt, busy, tstart, txpd}), 0);
        pbusy = 0;
        ticks = 0;
        ptx = 8'h00;
      end else begin
        if (pbusy && txck) ticks++;
        check("busy_rise", 32'(busy && !pbusy), 32'(tstart));
        if (tstart) begin
          check("tstart_pending", 32'(q.size() != 0), 1);
          if (q.size() != 0) begin
            e = q.pop_front();
            check("tstart_cyc", cyc, e.c);
            check("ack", 32'(ack), 32'(4'b1 << e.w));
            check("gnt", 32'(gnt), 32'(4'b1 << e.w));
            check("txpd", 32'(txpd), 32'(e.b));
            check("gap", 32'(pbusy), 0);
          end
          ticks = 0;
        end else begin
          check("ack_quiet", 32'(ack), 0);
          check("txpd_hold", 32'(txpd), 32'(ptx));
        end
        if (pbusy && !busy) begin
          check("frame_ticks", ticks, FT);
          check("end_pending", 32'(eq.size() != 0), 1);
          if (eq.size() != 0) begin
            ec = eq.pop_front();
            check("end_cyc", cyc, ec);
          end
        end
        if (!busy) check("gnt_idle", 32'(gnt), 0);
        ptx = txpd;
        pbusy = busy;
      end
    end
  end
  initial begin
    logic [3:0] rq;
    int chg [4];
    int ng;
    rq = 4'b0;
    for (int n = 0; n < 4; n++) begin
      pdv[n] = 8'h00;
      chg[n] = 0;
    end
    step(1, 4'b0, 0);
    step(1, 4'b0, 1);
    for (int i = 0; i < 14; i++) step(0, 4'b0, i[0]);
    pdv[2] = 8'hA5;
    pdv[1] = 8'h5A;
    step(0, 4'b0100, 0);
    step(0, 4'b0010, 1);
    for (int i = 0; i < 300 && m_busy; i++) step(0, m_ticks < 5 ? 4'b0010 : 4'b0000, 1'($urandom_range(0, 1)));
    step(0, 4'b0, 0);
    for (int n = 0; n < 4; n++) pdv[n] = 8'(8'h10 + n);
    ng = 0;
    for (int i = 0; i < 300 && ng < 5; i++) begin
      step(0, 4'b1111, 1);
      ng += int'(new_grant);
    end
    for (int i = 0; i < 40 && m_busy; i++) step(0, 4'b1111, 1);
    step(0, 4'b1111, 0);
    for (int i = 0; i < 5; i++) step(0, 4'b1111, 1);
    step(1, 4'b1111, 0);
    step(0, 4'b1111, 0);
    for (int i = 0; i < 40 && m_busy; i++) step(0, 4'b0, 1);
    for (int c = 0; c < 3000; c++) begin
      for (int n = 0; n < 4; n++) begin
        if (chg[n] > 0) begin
          chg[n]--;
          if (chg[n] == 0) begin
            rq[n] = 1'($urandom_range(0, 1));
            pdv[n] = 8'($urandom);
          end
        end else if (!rq[n]) begin
          if ($urandom_range(0, 3) == 0) begin
            rq[n] = 1'b1;
            pdv[n] = 8'($urandom);
          end
        end else if ($urandom_range(0, 39) == 0) rq[n] = 1'b0;
      end
      step(c == 1500 ? 1'b1 : 1'b0, rq, $urandom_range(0, 2) == 0);
      if (new_grant) chg[last_w] = 2;
    end
    for (int i = 0; i < 60 && m_busy; i++) step(0, 4'b0, 1);
    repeat (3) step(0, 4'b0, 0);
    @(posedge clk);
    #2;
    check("q_drain", q.size(), 0);
    check("eq_drain", eq.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
